// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: single-outstanding ICache fetch, next-PC prediction and a decoupling queue.
// Optional fetch/flush statistics counters are enabled with `define IF_STAT_EN.
module fetch_queue_unit #(
  parameter int          FQ_WIDTH = 2,
  parameter int          FQ_DEPTH = 1 << FQ_WIDTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  output logic                icache_query_en,
  output logic [31:0]         icache_query_pc,
  input  logic                icache_data_en,
  input  logic [31:0]         icache_data,
  output logic [31:0]         predict_query_pc,
  input  logic                predict_result,
  input  logic                jalr_result_en,
  input  logic [31:0]         jalr_result,
  input  logic                flush_en,
  input  logic [31:0]         flush_pc,
  input  logic                deq_ready,
  output logic                new_instruction_en,
  output logic [31:0]         new_pc,
  output logic [31:0]         new_instruction,
  output logic                new_predict_result,
  output logic [FQ_WIDTH:0]   fq_count
`ifdef IF_STAT_EN
  ,output logic [31:0]        stat_fetched
  ,output logic [31:0]        stat_flushed
`endif
);

  // state         | meaning
  // S_FETCH       | issue a fetch for pc_q when the queue has room
  // S_WAIT_ICACHE | one fetch outstanding, waiting for the ICache response
  // S_WAIT_JALR   | jalr fetched, waiting for its resolved target
  typedef enum logic [1:0] {S_FETCH, S_WAIT_ICACHE, S_WAIT_JALR} state_e;

  localparam logic [6:0]          OP_JAL    = 7'b1101111;
  localparam logic [6:0]          OP_JALR   = 7'b1100111;
  localparam logic [6:0]          OP_BRANCH = 7'b1100011;
  localparam logic [FQ_WIDTH:0]   DEPTH_C   = FQ_DEPTH[FQ_WIDTH:0];

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  discard_q, discard_d;
  logic                  query_en_q, query_en_d;
  logic [31:0]           query_pc_q, query_pc_d;
  logic [FQ_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [FQ_WIDTH:0]     count_q, count_d;
  logic                  push, pop, resp_drop, is_branch;
  logic [31:0]           imm_j, imm_b;

  logic [31:0]           pc_mem_q   [FQ_DEPTH];
  logic [31:0]           inst_mem_q [FQ_DEPTH];
  logic                  pred_mem_q [FQ_DEPTH];

  assign imm_j     = {{12{icache_data[31]}}, icache_data[19:12], icache_data[20], icache_data[30:21], 1'b0};
  assign imm_b     = {{20{icache_data[31]}}, icache_data[7], icache_data[30:25], icache_data[11:8], 1'b0};
  assign is_branch = (icache_data[6:0] == OP_BRANCH) && (icache_data[14:13] != 2'b01);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    query_en_d = 1'b0;
    query_pc_d = query_pc_q;
    push       = 1'b0;
    resp_drop  = 1'b0;
    pop        = (count_q != '0) && deq_ready && !flush_en;
    case (state_q)
      S_FETCH: begin
        if (!flush_en && (count_q < DEPTH_C)) begin
          query_en_d = 1'b1;
          query_pc_d = pc_q;
          state_d    = S_WAIT_ICACHE;
        end
      end
      S_WAIT_ICACHE: begin
        if (icache_data_en) begin
          state_d = S_FETCH;
          if (flush_en || discard_q) begin
            resp_drop = 1'b1;
            discard_d = 1'b0;
          end else begin
            push = 1'b1;
            if (icache_data[6:0] == OP_JAL)
              pc_d = pc_q + imm_j;
            else if (icache_data[6:0] == OP_JALR)
              state_d = S_WAIT_JALR;
            else if (is_branch && predict_result)
              pc_d = pc_q + imm_b;
            else
              pc_d = pc_q + 32'd4;
          end
        end else if (flush_en) begin
          discard_d = 1'b1;
        end
      end
      S_WAIT_JALR: begin
        if (flush_en) begin
          state_d = S_FETCH;
        end else if (jalr_result_en) begin
          pc_d    = jalr_result;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (flush_en) pc_d = flush_pc;
  end

  // Flush empties the queue outright; pointers restart at slot 0.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      count_d = count_q + {{FQ_WIDTH{1'b0}}, push} - {{FQ_WIDTH{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      query_en_q <= 1'b0;
      query_pc_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      query_en_q <= query_en_d;
      query_pc_q <= query_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
        pred_mem_q[i] <= 1'b0;
      end
    end else if (rdy_in && push) begin
      pc_mem_q[tail_q]   <= pc_q;
      inst_mem_q[tail_q] <= icache_data;
      pred_mem_q[tail_q] <= is_branch && predict_result;
    end
  end

  assign icache_query_en    = query_en_q;
  assign icache_query_pc    = query_pc_q;
  assign predict_query_pc   = pc_q;
  assign new_instruction_en = (count_q != '0);
  assign new_pc             = pc_mem_q[head_q];
  assign new_instruction    = inst_mem_q[head_q];
  assign new_predict_result = pred_mem_q[head_q];
  assign fq_count           = count_q;

`ifdef IF_STAT_EN
  logic [31:0] stat_fetched_q, stat_flushed_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else if (rdy_in) begin
      stat_fetched_q <= stat_fetched_q + {31'd0, push};
      stat_flushed_q <= stat_flushed_q + (flush_en ? {{(31-FQ_WIDTH){1'b0}}, count_q} : 32'd0)
                        + {31'd0, resp_drop};
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: ICache responses are driven by hand and every
// expected PC/queue value is written out as a constant.
module tb_fetch_queue_unit;

  localparam int FQ_WIDTH = 2;

  localparam logic [31:0] ADDI  = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] BEQ16 = 32'h00000863;  // beq x0,x0,+16
  localparam logic [31:0] JALR  = 32'h00008067;  // jalr x0,0(x1)
  localparam logic [31:0] JAL64 = 32'h0400006F;  // jal x0,+64

  logic                clk_in = 1'b0;
  logic                rst_n_in = 1'b0;
  logic                rdy_in = 1'b1;
  logic                icache_query_en;
  logic [31:0]         icache_query_pc;
  logic                icache_data_en = 1'b0;
  logic [31:0]         icache_data = '0;
  logic [31:0]         predict_query_pc;
  logic                predict_result = 1'b0;
  logic                jalr_result_en = 1'b0;
  logic [31:0]         jalr_result = '0;
  logic                flush_en = 1'b0;
  logic [31:0]         flush_pc = '0;
  logic                deq_ready = 1'b1;
  logic                new_instruction_en;
  logic [31:0]         new_pc;
  logic [31:0]         new_instruction;
  logic                new_predict_result;
  logic [FQ_WIDTH:0]   fq_count;
`ifdef IF_STAT_EN
  logic [31:0]         stat_fetched;
  logic [31:0]         stat_flushed;
`endif

  int checks = 0;
  int failures = 0;

  fetch_queue_unit #(.FQ_WIDTH(FQ_WIDTH), .RESET_PC(32'h0)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .rdy_in             (rdy_in),
    .icache_query_en    (icache_query_en),
    .icache_query_pc    (icache_query_pc),
    .icache_data_en     (icache_data_en),
    .icache_data        (icache_data),
    .predict_query_pc   (predict_query_pc),
    .predict_result     (predict_result),
    .jalr_result_en     (jalr_result_en),
    .jalr_result        (jalr_result),
    .flush_en           (flush_en),
    .flush_pc           (flush_pc),
    .deq_ready          (deq_ready),
    .new_instruction_en (new_instruction_en),
    .new_pc             (new_pc),
    .new_instruction    (new_instruction),
    .new_predict_result (new_predict_result),
    .fq_count           (fq_count)
`ifdef IF_STAT_EN
    ,.stat_fetched      (stat_fetched)
    ,.stat_flushed      (stat_flushed)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a query pulse at a falling edge and checks its address.
  task automatic expect_query(input string tag, input logic [31:0] pc_exp);
    int n = 0;
    while (icache_query_en !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_seen"}, {31'd0, icache_query_en}, 32'd1);
    check({tag, "_pc"}, icache_query_pc, pc_exp);
  endtask

  task automatic respond(input logic [31:0] instr, input logic pred);
    icache_data_en = 1'b1;
    icache_data    = instr;
    predict_result = pred;
    @(negedge clk_in);
    icache_data_en = 1'b0;
    predict_result = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc_exp,
                            input logic [31:0] ins_exp, input logic pred_exp);
    check({tag, "_valid"}, {31'd0, new_instruction_en}, 32'd1);
    check({tag, "_pc"}, new_pc, pc_exp);
    check({tag, "_ins"}, new_instruction, ins_exp);
    check({tag, "_pred"}, {31'd0, new_predict_result}, {31'd0, pred_exp});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_qen"}, {31'd0, icache_query_en}, 32'd0);
    check({tag, "_qpc"}, icache_query_pc, 32'd0);
    check({tag, "_ppc"}, predict_query_pc, 32'd0);
    check({tag, "_hval"}, {31'd0, new_instruction_en}, 32'd0);
    check({tag, "_hpc"}, new_pc, 32'd0);
    check({tag, "_hins"}, new_instruction, 32'd0);
    check({tag, "_hpred"}, {31'd0, new_predict_result}, 32'd0);
    check({tag, "_cnt"}, {29'd0, fq_count}, 32'd0);
  endtask

  // Counts query pulses over a window of falling edges.
  task automatic count_queries(input int cycles, output int n, output logic [31:0] last_pc);
    n = 0;
    last_pc = '0;
    for (int i = 0; i < cycles; i++) begin
      if (icache_query_en === 1'b1) begin
        n++;
        last_pc = icache_query_pc;
      end
      @(negedge clk_in);
    end
  endtask

  initial begin
    int          nq;
    logic [31:0] qpc;

    @(negedge clk_in);
    check_all_zero("reset");
    rst_n_in = 1'b1;

    // Straight-line code, dispatcher always ready.
    for (int k = 0; k < 3; k++) begin
      expect_query($sformatf("line_q%0d", k), 32'(4 * k));
      respond(ADDI, 1'b0);
      check_head($sformatf("line_h%0d", k), 32'(4 * k), ADDI, 1'b0);
    end

    // Fill the queue with the dispatcher stalled.
    expect_query("full_q0", 32'd12);
    check("full_cnt0", {29'd0, fq_count}, 32'd0);
    deq_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) expect_query($sformatf("full_q%0d", k), 32'(12 + 4 * k));
      respond(ADDI, 1'b0);
    end
    count_queries(5, nq, qpc);
    check("full_noquery", 32'(nq), 32'd0);
    check("full_cnt4", {29'd0, fq_count}, 32'd4);
    check_head("full_head", 32'd12, ADDI, 1'b0);
    deq_ready = 1'b1;
    @(negedge clk_in);
    deq_ready = 1'b0;
    check("pop1_cnt", {29'd0, fq_count}, 32'd3);
    check("pop1_head", new_pc, 32'd16);
    count_queries(6, nq, qpc);
    check("pop1_nq", 32'(nq), 32'd1);
    check("pop1_qpc", qpc, 32'd28);
    respond(ADDI, 1'b0);
    check("refill_cnt", {29'd0, fq_count}, 32'd4);

    // Flush while idle in FETCH with a full queue.
    flush_en = 1'b1;
    flush_pc = 32'd8;
    @(negedge clk_in);
    flush_en = 1'b0;
    check("fl_fetch_cnt", {29'd0, fq_count}, 32'd0);
    check("fl_fetch_val", {31'd0, new_instruction_en}, 32'd0);
    deq_ready = 1'b1;

    // Predicted-taken and not-taken branches.
    expect_query("br_q0", 32'd8);
    respond(BEQ16, 1'b1);
    check_head("br_taken", 32'd8, BEQ16, 1'b1);
    expect_query("br_q1", 32'd24);
    respond(BEQ16, 1'b0);
    check_head("br_ntaken", 32'd24, BEQ16, 1'b0);
    expect_query("br_q2", 32'd28);
    respond(ADDI, 1'b0);

    // jalr stalls fetch until its target arrives.
    expect_query("jalr_q", 32'h20);
    respond(JALR, 1'b1);
    check_head("jalr_head", 32'h20, JALR, 1'b0);
    count_queries(5, nq, qpc);
    check("jalr_stall", 32'(nq), 32'd0);
    jalr_result_en = 1'b1;
    jalr_result    = 32'h100;
    @(negedge clk_in);
    jalr_result_en = 1'b0;
    expect_query("jalr_tgt", 32'h100);

    respond(JAL64, 1'b0);
    check_head("jal_head", 32'h100, JAL64, 1'b0);
    expect_query("jal_tgt", 32'h140);

    // Flush with a fetch in flight and three entries queued.
    deq_ready = 1'b0;
    respond(ADDI, 1'b0);
    expect_query("fl_q1", 32'h144);
    respond(ADDI, 1'b0);
    expect_query("fl_q2", 32'h148);
    respond(ADDI, 1'b0);
    expect_query("fl_q3", 32'h14C);
    check("fl_cnt3", {29'd0, fq_count}, 32'd3);
    flush_en = 1'b1;
    flush_pc = 32'h200;
    @(negedge clk_in);
    flush_en = 1'b0;
    check("fl_wait_cnt", {29'd0, fq_count}, 32'd0);
    check("fl_wait_val", {31'd0, new_instruction_en}, 32'd0);
    respond(ADDI, 1'b0);
    check("fl_stale_cnt", {29'd0, fq_count}, 32'd0);
    check("fl_stale_qen", {31'd0, icache_query_en}, 32'd0);
    expect_query("fl_restart", 32'h200);
    check("fl_ppc", predict_query_pc, 32'h200);

    // Flush in the same cycle as the response.
    icache_data_en = 1'b1;
    icache_data    = ADDI;
    flush_en       = 1'b1;
    flush_pc       = 32'h300;
    @(negedge clk_in);
    icache_data_en = 1'b0;
    flush_en       = 1'b0;
    check("fl_same_cnt", {29'd0, fq_count}, 32'd0);
    expect_query("fl_same_q", 32'h300);

    // Asynchronous reset between clock edges.
    respond(ADDI, 1'b0);
    expect_query("rst_pre_q", 32'h304);
    check("rst_pre_cnt", {29'd0, fq_count}, 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    expect_query("rst_first", 32'h0);

    // rdy_in low freezes everything, including a response.
    rdy_in = 1'b0;
    respond(ADDI, 1'b0);
    @(negedge clk_in);
    check("rdy_hold_qen", {31'd0, icache_query_en}, 32'd1);
    check("rdy_hold_cnt", {29'd0, fq_count}, 32'd0);
    rdy_in = 1'b1;
    respond(ADDI, 1'b0);
    check("rdy_push_cnt", {29'd0, fq_count}, 32'd1);
    check_head("rdy_head", 32'h0, ADDI, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
